// File: rtl/uart_rx_to_mem_pkg.sv
// Shared definitions for the UART-receive-to-matrix-memory loader.
// State encoding, element byte count and default inter-byte timeout.
package uart_rx_to_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HI_BYTE = 3'd1,
        ST_LO_BYTE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_e;

    localparam int BYTES_PER_ELEM  = 2;
    localparam int DEFAULT_TIMEOUT = 1_000_000;

endpackage

// File: rtl/uart_rx_to_mem_if.sv
// Byte-receive and memory-write signals of the matrix loader.
// master = loader side (consumes bytes, issues writes); slave = environment side.
interface uart_rx_to_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              write_en;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_value;

    modport master (
        input  rx_valid, rx_byte,
        output write_en, write_address, write_value
    );

    modport slave (
        output rx_valid, rx_byte,
        input  write_en, write_address, write_value
    );
endinterface

// File: rtl/uart_rx_to_mem_rx_byte_timer.sv
// Loadable saturating cycle counter: clear, load, count enable, expiry flag.
// expired is high while the count sits at MAX_COUNT-1; the count never wraps.
module rx_byte_timer #(
    parameter int MAX_COUNT = 1_000_000,
    parameter int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          expired
);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_COUNT - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en && (count_q < LIMIT)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q >= LIMIT);

endmodule

// File: rtl/uart_rx_to_mem.sv
// Reassembles high-byte-first 16-bit elements from UART bytes and writes them row-major.
// Optional trailing modulo-256 checksum byte when RX_CHECKSUM_EN is defined.
module uart_rx_to_mem
    import uart_rx_to_mem_pkg::*;
#(
    parameter int ROW            = 2,
    parameter int COLUMN         = 2,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    uart_rx_to_mem_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] elem_count
);
    localparam int NUM_ELEM = ROW * COLUMN;
    localparam int ELEM_W   = BYTES_PER_ELEM * 8;

    state_e            state_q, state_d;
    logic              load_start_q;
    logic [7:0]        hi_q, hi_d;
    logic              write_en_q, write_en_d;
    logic [ADDR_W-1:0] write_address_q, write_address_d;
    logic [DATA_W-1:0] write_value_q, write_value_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] elem_count_q, elem_count_d;
`ifdef RX_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              arm;
    logic              is_last;
    logic              arm_go, data_acc, tmr_clr, tmr_en, tmr_expired;
    logic [ELEM_W-1:0] elem_w;

    assign rx_valid = bus.rx_valid;
    assign rx_byte  = bus.rx_byte;
    assign arm      = load_start & ~load_start_q;
    assign elem_w   = {hi_q, rx_byte};
    // Compare one bit wider so a full 2^ADDR_W-element matrix still terminates.
    assign is_last  = (({1'b0, elem_count_q} + (ADDR_W + 1)'(1)) == (ADDR_W + 1)'(NUM_ELEM));
    assign tmr_clr  = arm_go | data_acc;

    always_comb begin
        state_d         = state_q;
        hi_d            = hi_q;
        write_en_d      = 1'b0;
        write_address_d = write_address_q;
        write_value_d   = write_value_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        err_d           = err_q;
        elem_count_d    = elem_count_q;
        arm_go          = 1'b0;
        data_acc        = 1'b0;
        tmr_en          = 1'b0;
`ifdef RX_CHECKSUM_EN
        sum_d           = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (arm) begin
                    arm_go       = 1'b1;
                    elem_count_d = '0;
                    err_d        = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_HI_BYTE;
                end
            end
            ST_HI_BYTE: begin
                if (rx_valid) begin
                    data_acc = 1'b1;
                    hi_d     = rx_byte;
                    state_d  = ST_LO_BYTE;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_ERROR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_LO_BYTE: begin
                if (rx_valid) begin
                    data_acc        = 1'b1;
                    write_en_d      = 1'b1;
                    write_value_d   = DATA_W'(elem_w);
                    write_address_d = elem_count_q;
                    state_d         = ST_WRITE;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_ERROR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WRITE: begin
                elem_count_d = elem_count_q + ADDR_W'(1);
                if (is_last) begin
`ifdef RX_CHECKSUM_EN
                    // A strobe landing here is already the checksum byte.
                    if (rx_valid) begin
                        if (rx_byte == sum_q) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_ERROR;
                        end
                    end else begin
                        state_d = ST_CHECK;
                    end
`else
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
`endif
                end else if (rx_valid) begin
                    data_acc = 1'b1;
                    hi_d     = rx_byte;
                    state_d  = ST_LO_BYTE;
                end else begin
                    state_d = ST_HI_BYTE;
                end
            end
`ifdef RX_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_valid) begin
                    if (rx_byte == sum_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_ERROR;
                    end
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_ERROR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef RX_CHECKSUM_EN
        if (arm_go) begin
            sum_d = '0;
        end else if (data_acc) begin
            sum_d = sum_q + rx_byte;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            load_start_q    <= 1'b0;
            hi_q            <= '0;
            write_en_q      <= 1'b0;
            write_address_q <= '0;
            write_value_q   <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            elem_count_q    <= '0;
`ifdef RX_CHECKSUM_EN
            sum_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            load_start_q    <= load_start;
            hi_q            <= hi_d;
            write_en_q      <= write_en_d;
            write_address_q <= write_address_d;
            write_value_q   <= write_value_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
            elem_count_q    <= elem_count_d;
`ifdef RX_CHECKSUM_EN
            sum_q           <= sum_d;
`endif
        end
    end

    rx_byte_timer #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst),
        .clr      (tmr_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    assign bus.write_en      = write_en_q;
    assign bus.write_address = write_address_q;
    assign bus.write_value   = write_value_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign elem_count        = elem_count_q;

endmodule
